// File: rtl/exe_muldiv_ctrl_pkg.sv
// exe_muldiv_ctrl_pkg: shared widths, opcodes and FSM states for the iterative RV64M unit.
package exe_muldiv_ctrl_pkg;
  localparam int XLEN = 64;
  localparam int OP_W = 4;
  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX, MD_DONE} md_state_e;
  localparam logic [OP_W-1:0] MD_MUL    = 4'd0;
  localparam logic [OP_W-1:0] MD_MULH   = 4'd1;
  localparam logic [OP_W-1:0] MD_MULHSU = 4'd2;
  localparam logic [OP_W-1:0] MD_MULHU  = 4'd3;
  localparam logic [OP_W-1:0] MD_DIV    = 4'd4;
  localparam logic [OP_W-1:0] MD_DIVU   = 4'd5;
  localparam logic [OP_W-1:0] MD_REM    = 4'd6;
  localparam logic [OP_W-1:0] MD_REMU   = 4'd7;
  localparam logic [OP_W-1:0] MD_MULW   = 4'd8;
  localparam logic [OP_W-1:0] MD_DIVW   = 4'd9;
  localparam logic [OP_W-1:0] MD_DIVUW  = 4'd10;
  localparam logic [OP_W-1:0] MD_REMW   = 4'd11;
  localparam logic [OP_W-1:0] MD_REMUW  = 4'd12;
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction
endpackage

// File: rtl/exe_muldiv_ctrl_step.sv
// md_iter_step: one radix-2 iteration, shift-add multiply or restoring divide.
module md_iter_step
  import exe_muldiv_ctrl_pkg::*;
(
  input  logic              is_div,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opr,
  output logic [2*XLEN-1:0] acc_out
);
  logic [XLEN:0]   sum, rem;
  logic [XLEN-1:0] diff;
  always_comb begin
    sum = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opr} : '0);
    rem = acc_in[2*XLEN-1:XLEN-1];
    diff = rem[XLEN-1:0] - opr;
    acc_out = !is_div ? {sum, acc_in[XLEN-1:1]} :
              (rem >= {1'b0, opr}) ? {diff, acc_in[XLEN-2:0], 1'b1} : {acc_in[2*XLEN-2:0], 1'b0};
  end
endmodule

// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: iterative RV64M multiply/divide with sign fix-up and divide special cases.
module exe_muldiv_ctrl
  import exe_muldiv_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [OP_W-1:0] md_op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  output logic            stall_req,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  md_state_e         state;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, prod, mul_v;
  logic [XLEN-1:0]   opr, ext_a, ext_b, mag_a, mag_b, spec_res, div_v, fix_raw, fix_val;
  logic              r_div, r_w, r_rem, r_hi, r_neg;
  logic              w_op, div_op, rem_op, hi_op, sg_a, sg_b, neg_a, neg_b, illegal, div0, ovf, special;
  always_comb begin
    w_op = md_op inside {[MD_MULW:MD_REMUW]};
    div_op = md_op inside {[MD_DIV:MD_REMU], [MD_DIVW:MD_REMUW]};
    rem_op = md_op inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
    hi_op = md_op inside {MD_MULH, MD_MULHSU, MD_MULHU};
    sg_a = md_op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    sg_b = md_op inside {MD_MULH, MD_DIV, MD_REM, MD_DIVW, MD_REMW};
    illegal = md_op > MD_REMUW;
    ext_a = w_op ? (sg_a ? sext32(op1[31:0]) : {32'b0, op1[31:0]}) : op1;
    ext_b = w_op ? (sg_b ? sext32(op2[31:0]) : {32'b0, op2[31:0]}) : op2;
    neg_a = sg_a & ext_a[XLEN-1];
    neg_b = sg_b & ext_b[XLEN-1];
    mag_a = neg_a ? -ext_a : ext_a;
    mag_b = neg_b ? -ext_b : ext_b;
    div0 = div_op & (ext_b == '0);
    ovf = div_op & sg_a & (&ext_b) & (ext_a == (w_op ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    special = illegal | div0 | ovf;
    // a zero-divisor remainder is the dividend, sign-extended from bit 31 for every W op
    spec_res = illegal ? '0 :
               div0 ? (rem_op ? (w_op ? sext32(op1[31:0]) : op1) : '1) :
               rem_op ? '0 : ext_a;
    prod = r_w ? acc >> 32 : acc;
    mul_v = r_neg ? -prod : prod;
    div_v = r_rem ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    fix_raw = r_div ? (r_neg ? -div_v : div_v) : (r_hi ? mul_v[2*XLEN-1:XLEN] : mul_v[XLEN-1:0]);
    fix_val = r_w ? sext32(fix_raw[31:0]) : fix_raw;
  end
  md_iter_step u_step (.is_div(r_div), .acc_in(acc), .opr(opr), .acc_out(acc_nxt));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt <= '0;
      acc <= '0;
      opr <= '0;
      {r_div, r_w, r_rem, r_hi, r_neg} <= '0;
      done <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= MD_IDLE;
      done <= 1'b0;
    end else begin
      case (state)
        MD_IDLE: begin
          done <= 1'b0;
          if (start) begin
            {r_div, r_w, r_rem, r_hi} <= {div_op, w_op, rem_op, hi_op};
            r_neg <= (div_op & rem_op) ? neg_a : neg_a ^ neg_b;
            cnt <= w_op ? 6'd31 : 6'd63;
            // W divides start with the dividend in the upper quotient half so 32 steps suffice
            acc <= div_op ? {64'b0, w_op ? {mag_a[31:0], 32'b0} : mag_a} : {64'b0, mag_b};
            opr <= div_op ? mag_b : mag_a;
            if (special) begin
              result <= spec_res;
              done <= 1'b1;
              state <= MD_DONE;
            end else state <= MD_CALC;
          end
        end
        MD_CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 6'd1;
          if (cnt == 6'd0) state <= MD_FIX;
        end
        MD_FIX: begin
          result <= fix_val;
          done <= 1'b1;
          state <= MD_DONE;
        end
        default: begin
          done <= 1'b0;
          state <= MD_IDLE;
        end
      endcase
    end
  end
  assign stall_req = (state == MD_IDLE && start && !flush) || state == MD_CALC || state == MD_FIX;
  assign busy = state != MD_IDLE;
endmodule

// File: tb/tb_exe_muldiv_ctrl.sv
// tb_exe_muldiv_ctrl: directed vector table plus flush/reset/held-start sequences.
module tb_exe_muldiv_ctrl;
  logic        clk = 0, rst = 1, start = 0, flush = 0;
  logic [3:0]  md_op = 0;
  logic [63:0] op1 = 0, op2 = 0, result;
  logic        stall_req, busy, done;
  int          checks = 0, errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a, b, res;
    int          lat;
  } vec_t;
  vec_t vecs[17];

  exe_muldiv_ctrl dut (.clk(clk), .rst(rst), .start(start), .flush(flush), .md_op(md_op),
    .op1(op1), .op2(op2), .stall_req(stall_req), .busy(busy), .done(done), .result(result));

  always #5 clk = ~clk;

  task automatic chk(input logic [63:0] act, input logic [63:0] exp, input string nm);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] r, input int lat, input string nm);
    int cyc = 0, stall_lo = 0;
    @(negedge clk);
    md_op = o; op1 = a; op2 = b; start = 1;
    #1 chk(64'(stall_req), 64'd1, {nm, " stall_c0"});
    @(posedge clk);
    #1 start = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        cyc = c;
        break;
      end
      if (!stall_req) stall_lo++;
    end
    chk(64'(cyc), 64'(lat), {nm, " done_cycle"});
    chk(result, r, {nm, " result"});
    chk(64'({stall_req, busy}), 64'b01, {nm, " stall_busy_at_done"});
    chk(64'(stall_lo), 64'd0, {nm, " stall_gaps"});
  endtask

  initial begin
    vecs[0]  = '{4'd13, 64'd9, 64'd9, 64'd0, 1};
    vecs[1]  = '{4'd0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
    vecs[2]  = '{4'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
    vecs[3]  = '{4'd3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
    vecs[4]  = '{4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
    vecs[5]  = '{4'd4, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66};
    vecs[6]  = '{4'd6, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66};
    vecs[7]  = '{4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66};
    vecs[8]  = '{4'd9, 64'h1_0000_0010, 64'd4, 64'd4, 34};
    vecs[9]  = '{4'd4, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
    vecs[10] = '{4'd7, 64'd5, 64'd0, 64'd5, 1};
    vecs[11] = '{4'd4, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
    vecs[12] = '{4'd11, 64'h8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
    vecs[13] = '{4'd8, 64'hFFFF_FFFF, 64'd3, 64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[14] = '{4'd12, 64'h7_0000_0005, 64'h9_0000_0000, 64'd5, 1};
    vecs[15] = '{4'd10, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[16] = '{4'd11, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk(64'({busy, done, stall_req}), 64'b000, "reset_flags");
    chk(result, 64'd0, "reset_result");

    foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, $sformatf("vec%0d", i));

    // flush in cycle 10 of a DIV, result must keep the last vector's value
    @(negedge clk);
    md_op = 4'd4; op1 = 64'd100; op2 = 64'd7; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk(64'({busy, done}), 64'b00, "flush_busy_done");
    chk(result, vecs[16].res, "flush_result_kept");
    run_op(4'd0, 64'd2, 64'd3, 64'd6, 66, "mul_after_flush");

    // synchronous reset in the middle of CALC
    @(negedge clk);
    md_op = 4'd0; op1 = 64'd11; op2 = 64'd13; start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (20) @(negedge clk);
    rst = 1; flush = 1; start = 1;
    @(negedge clk);
    rst = 0; flush = 0; start = 0;
    chk(64'({busy, done, stall_req}), 64'b000, "rst_mid_flags");
    chk(result, 64'd0, "rst_mid_result");

    // start held high through busy and DONE; operands change while busy
    begin
      int cyc = 0, pulses = 0;
      @(negedge clk);
      md_op = 4'd0; op1 = 64'd2; op2 = 64'd3; start = 1;
      @(posedge clk);
      #1 op1 = 64'd5;
      for (int c = 1; c <= 100; c++) begin
        @(negedge clk);
        if (done) begin
          cyc = c;
          pulses++;
          break;
        end
      end
      chk(64'(cyc), 64'd66, "held_done_cycle");
      chk(result, 64'd6, "held_no_relatch");
      @(negedge clk);
      chk(64'({busy, done}), 64'b00, "held_no_relaunch");
      start = 0;
      repeat (3) @(negedge clk);
      if (done) pulses++;
      chk(64'(pulses), 64'd1, "held_single_pulse");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
